stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Downstream consumer of the clock-divider output.
- Samples the divided square wave (tick_in) in the system clk domain and counts one unit per tick rising edge.
- Counts minutes:seconds in BCD, 00:00 to 59:59.
- Runs a start/stop/clear FSM and drives the divider's enable, so the divider only runs while the stopwatch is counting.
- Outputs feed the 7-segment display scanner.

Parameters:
- WRAP, 1: 1 = roll 59:59 -> 00:00 and pulse ovf; 0 = saturate at 59:59 and enter DONE.

Ports:
- clk  input  1  system clock; same clock that drives the divider.
- rst  input  1  asynchronous, active-high reset.
- tick_in  input  1  divided clock from the divider; a registered level in the clk domain, so no synchronizer is needed.
- btn_ss  input  1  start/stop button level, already debounced; edge-detected internally.
- btn_clr  input  1  clear button level, already debounced; edge-detected internally.
- div_en  output  1  enable to the divider; high only in state RUN.
- sec_ones  output  4  BCD 0-9.
- sec_tens  output  4  BCD 0-5.
- min_ones  output  4  BCD 0-9.
- min_tens  output  4  BCD 0-5.
- running  output  1  high in state RUN.
- ovf  output  1  one-clk pulse on wrap (WRAP=1 only).

Behaviour:
- Reset is clk-asynchronous, rst=1. It sets:
  - state=IDLE
  - all digits=0
  - tick_d, ss_d, clr_d = 0
  - div_en=0, running=0, ovf=0
- Edge detection, all from registers updated each clk:
  - tick_rise = tick_in & ~tick_d
  - ss_rise = btn_ss & ~ss_d
  - clr_rise = btn_clr & ~clr_d
- States: IDLE, RUN, PAUSE, DONE. Encoding is 2-bit binary.
- IDLE:
  - ss_rise -> RUN.
  - clr_rise is a no-op; digits are already 0.
- RUN:
  - tick_rise -> increment the count at the next clk edge.
  - ss_rise -> PAUSE.
  - clr_rise -> IDLE and digits=0.
- PAUSE:
  - ss_rise -> RUN.
  - clr_rise -> IDLE and digits=0.
  - tick_rise is ignored.
- DONE (WRAP=0 only):
  - Entered from RUN when a tick arrives at 59:59; count holds 59:59.
  - clr_rise -> IDLE and digits=0.
  - ss_rise is ignored.
- Increment chain, in order sec_ones -> sec_tens -> min_ones -> min_tens:
  - sec_ones: 9 -> 0 and carry.
  - sec_tens: 5 -> 0 and carry.
  - min_ones: 9 -> 0 and carry.
  - min_tens: 5 -> 0 and carry-out; the carry-out is the wrap event.
- Wrap event:
  - WRAP=1: all digits become 0 and ovf=1 for one clk; state stays RUN.
  - WRAP=0: digits hold 59:59 and state goes to DONE.
- Latency:
  - tick_in rising at clk edge n -> digits updated at edge n+1.
  - Button rising seen at edge n -> state and div_en change at edge n+1.
- Simultaneous events:
  - clr_rise beats ss_rise and tick_rise; the tick is discarded.
  - tick_rise together with ss_rise in RUN: the tick is counted and the state moves to PAUSE in the same edge.
- Divider interaction:
  - Dropping div_en resets the divider, so tick_in falls within 1-2 clk.
  - tick_d tracks tick_in continuously, including in PAUSE and IDLE, so no spurious rise occurs on resume.
- Digits never leave their legal BCD range; illegal values are unreachable.
- rst asserted mid-count returns to the reset values immediately, without waiting for clk.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_DONE=3
  - digit limits SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9, MIN_TENS_MAX=5
- One natural sub-module: bcd_digit_cnt.
  - Parameter MAX; inputs inc and clr; outputs q[3:0] and carry.
  - carry = inc & (q==MAX).
  - Instantiated 4 times and chained inc <- previous carry.
- The FSM and edge detectors stay in the top module.

Test Plan:
- Reset/idle: assert rst mid-simulation with no clk edge -> all digits 0, div_en=0, state IDLE; tick_in pulses while IDLE -> digits stay 00:00.
- Basic count: divider cnt_num=4, press start -> div_en=1 next clk; after 12 tick rises -> 00:12; a tick at 00:59 -> 01:00.
- Pause/resume: at 00:07 press btn_ss -> PAUSE, div_en=0; 20 clk of forced tick_in toggling -> still 00:07; press again -> 00:08 after the next tick rise.
- Wrap: preload by running to 59:59 with WRAP=1; next tick -> 00:00 with ovf=1 for exactly one clk. With WRAP=0 the same tick -> 59:59 held, DONE, div_en=0; btn_ss ignored; btn_clr -> 00:00, IDLE.
- Simultaneity: tick_rise and btn_clr rise in the same clk at 00:30 -> 00:00, IDLE. tick_rise and btn_ss rise in the same clk at 00:30 -> 00:31, PAUSE.
- Held button: btn_ss held high for 50 clk -> exactly one state transition.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants for the stopwatch: FSM state codes and per-digit BCD limits.
package stopwatch_ctrl_pkg;

    // 2-bit binary state encoding; the code values are also visible on the debug port.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Largest legal value of each display digit (mm:ss).
    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_cnt.sv
// One BCD digit that counts 0..MAX. A carry is raised when an increment hits MAX,
// so that digits can be chained with inc <- previous carry.
module bcd_digit_cnt #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    assign carry = inc & (q_q == MAX);
    assign q     = q_q;

    // Next digit value: clear wins, otherwise step and roll over at MAX.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc) begin
            q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    // Digit register, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: counts mm:ss in BCD on rising edges of the divider tick,
// runs the IDLE/RUN/PAUSE/DONE FSM and gates the divider through div_en.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       btn_ss,
    input  logic       btn_clr,
    output logic       div_en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       ovf,
    output logic [1:0] dbg_state_o
);

    logic [1:0] state_q, state_d;
    logic       tick_prev_q, ss_prev_q, clr_prev_q;
    logic       ovf_q;

    logic       tick_rise, ss_rise, clr_rise;
    logic       inc, clr_cnt;
    logic       c_so, c_st, c_mo, c_mt;
    logic       at_max, hold_max;

    assign tick_rise = tick_in & ~tick_prev_q;
    assign ss_rise   = btn_ss  & ~ss_prev_q;
    assign clr_rise  = btn_clr & ~clr_prev_q;

    assign at_max   = (sec_ones == SEC_ONES_MAX) && (sec_tens == SEC_TENS_MAX) &&
                      (min_ones == MIN_ONES_MAX) && (min_tens == MIN_TENS_MAX);
    // Without wrapping, a tick at 59:59 must not touch the digits.
    assign hold_max = ~WRAP & at_max;

    // FSM next state plus counter control; clear beats start/stop and tick.
    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        clr_cnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_rise) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (clr_rise) begin
                    state_d = ST_IDLE;
                    clr_cnt = 1'b1;
                end else begin
                    if (ss_rise) state_d = ST_PAUSE;
                    if (tick_rise) begin
                        if (hold_max) state_d = ST_DONE;
                        else          inc     = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (clr_rise) begin
                    state_d = ST_IDLE;
                    clr_cnt = 1'b1;
                end else if (ss_rise) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (clr_rise) begin
                    state_d = ST_IDLE;
                    clr_cnt = 1'b1;
                end
            end
        endcase
    end

    // State, edge-detector history and overflow pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            clr_prev_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_prev_q <= tick_in;
            ss_prev_q   <= btn_ss;
            clr_prev_q  <= btn_clr;
            ovf_q       <= WRAP & c_mt;
        end
    end

    bcd_digit_cnt #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .inc(inc),  .clr(clr_cnt), .q(sec_ones), .carry(c_so)
    );
    bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .inc(c_so), .clr(clr_cnt), .q(sec_tens), .carry(c_st)
    );
    bcd_digit_cnt #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .inc(c_st), .clr(clr_cnt), .q(min_ones), .carry(c_mo)
    );
    bcd_digit_cnt #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .inc(c_mo), .clr(clr_cnt), .q(min_tens), .carry(c_mt)
    );

    assign div_en      = (state_q == ST_RUN);
    assign running     = (state_q == ST_RUN);
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a wrapping and a saturating instance share stimulus and
// are compared each check point against a total-seconds reference model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic tick_in, btn_ss, btn_clr;

  logic       div_en_w[2], running_w[2], ovf_w[2];
  logic [3:0] so_w[2], st_w[2], mo_w[2], mt_w[2];
  logic [1:0] state_w[2];
  logic [20:0] obs[2];

  int total = 0;
  int bad   = 0;

  // Reference model: elapsed seconds and state code per instance (0 = saturating, 1 = wrapping).
  int m_cnt[2];
  int m_st[2];
  bit m_ovf[2];
  bit p_t, p_s, p_c;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  stopwatch_ctrl #(.WRAP(1'b0)) dut_w0 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .div_en(div_en_w[0]), .sec_ones(so_w[0]), .sec_tens(st_w[0]), .min_ones(mo_w[0]),
    .min_tens(mt_w[0]), .running(running_w[0]), .ovf(ovf_w[0]), .dbg_state_o(state_w[0])
  );

  stopwatch_ctrl #(.WRAP(1'b1)) dut_w1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .div_en(div_en_w[1]), .sec_ones(so_w[1]), .sec_tens(st_w[1]), .min_ones(mo_w[1]),
    .min_tens(mt_w[1]), .running(running_w[1]), .ovf(ovf_w[1]), .dbg_state_o(state_w[1])
  );

  assign obs[0] = {state_w[0], div_en_w[0], running_w[0], ovf_w[0], mt_w[0], mo_w[0], st_w[0], so_w[0]};
  assign obs[1] = {state_w[1], div_en_w[1], running_w[1], ovf_w[1], mt_w[1], mo_w[1], st_w[1], so_w[1]};

  // ---------------- reference model ----------------
  function automatic logic [20:0] exp_vec(input int w);
    int c;
    logic [1:0] s;
    logic [3:0] d_mt, d_mo, d_st, d_so;
    c = m_cnt[w];
    s = m_st[w][1:0];
    d_mt = 4'(c / 600);
    d_mo = 4'((c / 60) % 10);
    d_st = 4'((c % 60) / 10);
    d_so = 4'(c % 10);
    return {s, s == 2'd1, s == 2'd1, m_ovf[w], d_mt, d_mo, d_st, d_so};
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = 0;
      m_st[w]  = 0;
      m_ovf[w] = 1'b0;
    end
    p_t = 1'b0;
    p_s = 1'b0;
    p_c = 1'b0;
  endtask

  task automatic model_step(input int w, input bit tr, input bit sr, input bit cr);
    m_ovf[w] = 1'b0;
    if (cr && m_st[w] != 0) begin
      m_st[w]  = 0;
      m_cnt[w] = 0;
    end else begin
      case (m_st[w])
        0: if (sr) m_st[w] = 1;
        1: begin
          if (sr) m_st[w] = 2;
          if (tr) begin
            if (m_cnt[w] < 3599) m_cnt[w] = m_cnt[w] + 1;
            else if (w == 1) begin
              m_cnt[w] = 0;
              m_ovf[w] = 1'b1;
            end else m_st[w] = 3;
          end
        end
        2: if (sr) m_st[w] = 1;
        default: ;
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply input levels for one clock; the model sees the rises the bench itself created.
  task automatic step(input bit t, input bit s, input bit c);
    bit tr, sr, cr;
    tick_in = t;
    btn_ss  = s;
    btn_clr = c;
    tr = t & ~p_t;
    sr = s & ~p_s;
    cr = c & ~p_c;
    p_t = t;
    p_s = s;
    p_c = c;
    @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) model_step(w, tr, sr, cr);
  endtask

  task automatic run_ticks(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      repeat (half) step(1'b1, 1'b0, 1'b0);
      repeat (half) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press_ss();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_clr();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick_in = 1'b0;
    btn_ss = 1'b0;
    btn_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w)) begin
        bad++;
        $display("FAIL reset_init w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    rst = 1'b0;
    press_ss();
    run_ticks(5, 2);
    // Asynchronous reset between clock edges must act at once.
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w)) begin
        bad++;
        $display("FAIL reset_async w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_ticks(6, 2);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || obs[w][15:0] !== 16'h0000) begin
        bad++;
        $display("FAIL idle_ticks w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
  endtask

  task automatic test_basic_count();
    press_clr();
    step(1'b0, 1'b1, 1'b0);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (div_en_w[w] !== 1'b1 || obs[w] !== exp_vec(w)) begin
        bad++;
        $display("FAIL start_div_en w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    step(1'b0, 1'b0, 1'b0);
    run_ticks(12, 4);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || obs[w][15:0] !== 16'h0012) begin
        bad++;
        $display("FAIL count_00_12 w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    run_ticks(47, 4);
    step(1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || obs[w][15:0] !== 16'h0100) begin
        bad++;
        $display("FAIL carry_01_00 w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pause_resume();
    press_clr();
    press_ss();
    run_ticks(7, 4);
    press_ss();
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || div_en_w[w] !== 1'b0) begin
        bad++;
        $display("FAIL pause_enter w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    for (int i = 0; i < 20; i++) step(bit'(i % 2), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || obs[w][15:0] !== 16'h0007) begin
        bad++;
        $display("FAIL pause_hold w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    press_ss();
    run_ticks(1, 4);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || obs[w][15:0] !== 16'h0008) begin
        bad++;
        $display("FAIL resume_00_08 w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
  endtask

  task automatic test_wrap();
    press_clr();
    press_ss();
    run_ticks(3599, 1);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || obs[w][15:0] !== 16'h5959) begin
        bad++;
        $display("FAIL preload_59_59 w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    step(1'b1, 1'b0, 1'b0);
    // Wrapping instance: 00:00 with ovf; saturating instance: 59:59 held, DONE.
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w)) begin
        bad++;
        $display("FAIL wrap_edge w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    total++;
    if (ovf_w[1] !== 1'b1 || state_w[0] !== 2'd3 || div_en_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL wrap_flags: got ovf=%b st0=%0d en0=%b required ovf=1 st0=3 en0=0",
               ovf_w[1], state_w[0], div_en_w[0]);
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (ovf_w[1] !== 1'b0 || obs[1] !== exp_vec(1)) begin
      bad++;
      $display("FAIL ovf_one_clk: got %h required %h", obs[1], exp_vec(1));
    end
    press_ss();
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w)) begin
        bad++;
        $display("FAIL done_ignores_ss w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    press_clr();
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || obs[w][20:19] !== 2'd0 || obs[w][15:0] !== 16'h0000) begin
        bad++;
        $display("FAIL done_clear w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
  endtask

  task automatic test_simultaneous();
    press_clr();
    press_ss();
    run_ticks(30, 2);
    step(1'b1, 1'b0, 1'b1);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || obs[w][20:19] !== 2'd0 || obs[w][15:0] !== 16'h0000) begin
        bad++;
        $display("FAIL tick_with_clr w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    step(1'b0, 1'b0, 1'b0);
    press_ss();
    run_ticks(30, 2);
    step(1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 2; w++) begin
      total++;
      if (obs[w] !== exp_vec(w) || obs[w][20:19] !== 2'd2 || obs[w][15:0] !== 16'h0031) begin
        bad++;
        $display("FAIL tick_with_ss w%0d: got %h required %h", w, obs[w], exp_vec(w));
      end
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_held_button();
    int changes;
    logic [1:0] prev;
    changes = 0;
    prev = state_w[1];
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (state_w[1] !== prev) changes++;
      prev = state_w[1];
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (changes != 1 || obs[1] !== exp_vec(1)) begin
      bad++;
      $display("FAIL held_ss: got changes=%0d state=%h required changes=1 state=%h",
               changes, obs[1], exp_vec(1));
    end
  endtask

  task automatic test_random();
    bit t, s, c;
    t = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) t = ~t;
      s = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 40) == 0);
      step(t, s, c);
      for (int w = 0; w < 2; w++) begin
        total++;
        if (obs[w] !== exp_vec(w)) begin
          bad++;
          $display("FAIL random_%0d w%0d: got %h required %h", i, w, obs[w], exp_vec(w));
        end
      end
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_count();
    test_pause_resume();
    test_wrap();
    test_simultaneous();
    test_held_button();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
